esm_uart_rx: RTL and testbench
==============================

# esm_uart_rx

Parametrised UART receiver for the ESM serial CLI path, the next generation of the fixed 8N1 receiver behind the board UART pin. It oversamples the asynchronous RX line, verifies start bits, deserialises configurable-width frames with optional parity, and buffers received words in a first-word-fall-through FIFO with a valid/ready output. Framing, parity and overrun errors are reported as sticky flags for the CLI core.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit; even, ≥ 8
- DATA_BITS, 8, data bits per frame (5–9), LSB first
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only with ESM_UART_PARITY_EN
- FIFO_DEPTH, 16, power of two, ≥ 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_i  in  1  serial line, idle high, asynchronous to clk
- m_data  out  DATA_BITS  FIFO head word
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer pops the head when m_valid && m_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: good word dropped because FIFO full
- clr_err  in  1  one-cycle pulse clears all three sticky flags

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs reset to 0 (m_valid 0, fifo_count 0, flags 0); synchroniser flops reset to 1.
- rx_i passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick generator: divider DIV = round(CLK_HZ / (BAUD·OVERSAMPLE)), at least 1; runs free, one-cycle tick.
- FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE → START when the synchronised line is low. Tick counter restarts on entry.
- START: after OVERSAMPLE/2 ticks sample; low → DATA, high → IDLE (glitch rejected, no flag).
- DATA: sample every OVERSAMPLE ticks, shift LSB first; after DATA_BITS samples → PARITY (macro on) or STOP.
- PARITY: one sample; compare against XOR of data XOR PARITY_ODD; record mismatch → STOP.
- STOP: one sample. High and no parity mismatch → push word, → IDLE. High with mismatch → set parity_err, discard, → IDLE. Low → set frame_err, discard, → BREAK.
- BREAK: wait for synchronised line high → IDLE (a held-low break yields exactly one frame_err).
- FIFO push when full: word dropped, overrun set, unless a pop occurs the same cycle, in which case the push is accepted and overrun stays 0.
- Simultaneous push and pop when not full: fifo_count unchanged.
- clr_err coinciding with a new error event: the event wins (flag ends set).

## Timing
- Start edge to START-state entry: 3 clk (2 synchroniser, 1 FSM).
- Push occurs the clk after the stop-bit sample; m_valid and m_data valid the following clk (FWFT, registered).
- Stop sample taken at stop-bit mid-point, so the receiver is back in IDLE ~½ bit early, tolerating ±4% combined baud error at OVERSAMPLE 16.
- Pop: m_data shows the next word, or m_valid drops, the clk after the handshake.
- Reset assertion mid-frame: FSM to IDLE, FIFO emptied, partial word lost, immediately.

## Configuration
- ESM_UART_PARITY_EN defined: PARITY state present, frame carries one parity bit per PARITY_ODD, parity_err live.
- Undefined: no PARITY state, DATA → STOP directly, parity_err tied 0, PARITY_ODD ignored.

## Structure
- Package esm_uart_pkg: FSM state enum, function computing DIV from CLK_HZ/BAUD/OVERSAMPLE.
- Sub-module esm_sync_fifo (parametrised width/depth, FWFT, count output); receiver FSM and divider live in esm_uart_rx.

## Test plan
- Defaults, send 0x55 8N1 at 115200 (DIV 54), m_ready 1 → one m_valid pulse with m_data 0x55, ~1 bit after frame start+9.5 bits; no flags.
- 3-clk low glitch on rx_i → no push, no flag, FSM back in IDLE.
- Frame 0xA3 with stop bit 0, then line held low 3 bit-times → frame_err 1 once, fifo_count 0; clr_err → 0.
- m_ready 0, send 17 bytes 0x00..0x10 → fifo_count 16, overrun 1, popped sequence 0x00..0x0F.
- With ESM_UART_PARITY_EN, PARITY_ODD 0: 0x07 with parity 1 → accepted; with parity 0 → parity_err 1, nothing pushed.
- rst_n low during DATA bit 4, release, send 0x3C → only 0x3C received, no flags.

Source files
------------

// File: rtl/esm_uart_pkg.sv
// Shared definitions for the ESM UART receiver: FSM state encoding and the
// oversampling tick divider calculation.
package esm_uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;
    localparam uart_state_t ST_BREAK  = 3'd5;

    // Clocks per oversampling tick, rounded to nearest, never below 1.
    function automatic int calc_div(input longint clk_hz, input longint baud,
                                    input longint oversample);
        longint den;
        longint q;
        den = baud * oversample;
        if (den < 1) den = 1;
        q = (clk_hz + den / 2) / den;
        if (q < 1) q = 1;
        return int'(q);
    endfunction

endpackage

// File: rtl/esm_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a write while
// full is accepted only when a read retires the head in the same cycle.
module esm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/esm_uart_rx.sv
// Oversampling UART receiver feeding an FWFT FIFO, with sticky error flags.
// Define ESM_UART_PARITY_EN to add a parity bit after the data bits.
module esm_uart_rx
    import esm_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CW-1:0]        fifo_count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_err
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    logic                 rx_p0;
    logic                 rx_p1;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_lim;
    logic                 sample;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 vld_p1;
    logic                 stop_sample;
    logic                 frame_evt;
    logic                 parity_evt;
    logic                 overrun_evt;
    logic                 fifo_full;

`ifdef ESM_UART_PARITY_EN
    localparam uart_state_t ST_AFTER_DATA = ST_PARITY;
    assign parity_evt = stop_sample && rx_p1 && par_bad;
`else
    localparam uart_state_t ST_AFTER_DATA = ST_STOP;
    assign parity_evt = 1'b0;
`endif

    // Stage p0/p1: two-flop synchroniser, idles high like the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    assign tick     = (div_cnt == DW'(DIV - 1));
    assign tick_lim = (state == ST_START) ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1);
    assign sample   = tick && (tick_cnt == tick_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (tick) tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!rx_p1) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par_bad  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample) state <= rx_p1 ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) state <= ST_AFTER_DATA;
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        par_bad <= rx_p1 != ((^shreg) ^ (PARITY_ODD != 0));
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        vld_p1 <= rx_p1 && !par_bad;
                        state  <= rx_p1 ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_p1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift register holds still from the last data sample until the push.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && sample) shreg <= {rx_p1, shreg[DATA_BITS-1:1]};
    end

    assign stop_sample = (state == ST_STOP) && sample;
    assign frame_evt   = stop_sample && !rx_p1;
    assign overrun_evt = vld_p1 && fifo_full && !(m_valid && m_ready);

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_evt   || (frame_err  && !clr_err);
            parity_err <= parity_evt  || (parity_err && !clr_err);
            overrun    <= overrun_evt || (overrun    && !clr_err);
        end
    end

    esm_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (vld_p1),
        .wr_data  (shreg),
        .full     (fifo_full),
        .rd_en    (m_ready),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_esm_uart_rx.sv
// Directed bench for esm_uart_rx: clean frame, glitch, break, overrun,
// parity (when ESM_UART_PARITY_EN is defined) and mid-frame reset.
module tb_esm_uart_rx;
    import esm_uart_pkg::*;

    localparam int CLK_HZ = 10_000_000;
    localparam int BAUD   = 115_200;
    localparam int OS     = 16;
    localparam int DBITS  = 8;
    localparam int DEPTH  = 16;
    // 10 MHz / (115200 * 16) = 5.43 -> 5 clocks per tick, 80 clocks per bit.
    localparam int BIT    = 80;
`ifdef ESM_UART_PARITY_EN
    localparam bit USE_PAR = 1'b1;
`else
    localparam bit USE_PAR = 1'b0;
`endif
    // Stop sample at 9.5 bits (10.5 with parity) after the start edge, plus
    // 3 clk sync/FSM entry, 1 clk push and 0..4 clk tick phase, minus the
    // sync clocks already absorbed by the bit edges.
    localparam int LAT_LO = (19 + 2 * USE_PAR) * BIT / 2 - 2;
    localparam int LAT_HI = (19 + 2 * USE_PAR) * BIT / 2 + 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_i = 1'b1;
    logic             m_ready = 1'b0;
    logic             clr_err = 1'b0;
    logic [DBITS-1:0] m_data;
    logic             m_valid;
    logic [4:0]       fifo_count;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  rxq[$];
    logic        mv_q = 1'b0;
    time         t_rise = 0;
    time         t_start = 0;
    int          lat;

    always #5 clk = ~clk;

    esm_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DBITS),
        .PARITY_ODD (0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) rxq.push_back(m_data);
        if (m_valid && !mv_q) t_rise <= $time;
        mv_q <= m_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_clks(1);
        clr_err = 1'b0;
    endtask

    // Line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        rx_i = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < DBITS; i++) begin
            rx_i = d[i];
            wait_clks(BIT);
        end
        if (USE_PAR) begin
            rx_i = par_b;
            wait_clks(BIT);
        end
        rx_i = stop_b;
        wait_clks(BIT);
    endtask

    initial begin
        check("div_default", calc_div(100_000_000, 115_200, 16), 54);
        check("div_round_up", calc_div(100_000_000, 115_200, 8), 109);
        check("div_floor_one", calc_div(1000, 115_200, 16), 1);

        wait_clks(3);
        check("rst_m_valid", m_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_m_data", m_data, 0);
        check("rst_flags", {frame_err, parity_err, overrun}, 0);
        rst_n = 1'b1;
        wait_clks(2 * BIT);

        // Clean 0x55 frame (0x55 has even weight: even parity bit 0).
        m_ready = 1'b1;
        rxq.delete();
        t_start = $time;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_clks(BIT);
        lat = int'((t_rise - t_start) / 10);
        check("t1_pops", rxq.size(), 1);
        check("t1_data", (rxq.size() > 0) ? rxq[0] : 8'hEE, 8'h55);
        check("t1_latency", (lat >= LAT_LO) && (lat <= LAT_HI), 1);
        check("t1_flags", {frame_err, parity_err, overrun}, 0);
        check("t1_count", fifo_count, 0);

        // Short glitch: must not push or flag, and receiver must still work.
        rxq.delete();
        rx_i = 1'b0;
        wait_clks(3);
        rx_i = 1'b1;
        wait_clks(2 * BIT);
        check("glitch_pops", rxq.size(), 0);
        check("glitch_flags", {frame_err, parity_err, overrun}, 0);
        send_frame(8'hC6, 1'b1, 1'b0);
        wait_clks(BIT);
        check("after_glitch_data", (rxq.size() == 1) ? rxq[0] : 8'hEE, 8'hC6);

        // 0xA3 with stop low, then line held low for three bit-times.
        rxq.delete();
        send_frame(8'hA3, 1'b0, 1'b0);
        wait_clks(BIT);
        check("brk_frame_err", frame_err, 1);
        check("brk_count", fifo_count, 0);
        pulse_clr();
        check("brk_clr", frame_err, 0);
        wait_clks(2 * BIT);
        check("brk_single_err", frame_err, 0);
        rx_i = 1'b1;
        wait_clks(2 * BIT);
        check("brk_after_release", {frame_err, parity_err, overrun}, 0);
        check("brk_pops", rxq.size(), 0);

        // Fill beyond capacity with the consumer stalled.
        m_ready = 1'b0;
        rxq.delete();
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, ^(8'(i)));
        wait_clks(BIT);
        check("ovr_count", fifo_count, 16);
        check("ovr_flag", overrun, 1);
        check("ovr_head", m_data, 8'h00);
        check("ovr_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_clks(DEPTH + 4);
        check("ovr_pops", rxq.size(), 16);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("ovr_seq%0d", i), (i < rxq.size()) ? rxq[i] : 8'hEE, i);
        check("ovr_drained", {m_valid, fifo_count}, 0);
        pulse_clr();
        check("ovr_clr", overrun, 0);

`ifdef ESM_UART_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1.
        rxq.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(BIT);
        check("par_good_data", (rxq.size() == 1) ? rxq[0] : 8'hEE, 8'h07);
        check("par_good_flag", parity_err, 0);
        rxq.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(BIT);
        check("par_bad_flag", parity_err, 1);
        check("par_bad_pops", rxq.size(), 0);
        check("par_bad_ferr", frame_err, 0);
        pulse_clr();
        check("par_clr", parity_err, 0);
`else
        check("noparity_perr", parity_err, 0);
`endif

        // Reset in the middle of a frame after one word is buffered.
        m_ready = 1'b0;
        rxq.delete();
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clks(BIT);
        check("rstmid_pre_count", fifo_count, 1);
        rx_i = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b1;
            wait_clks(BIT);
        end
        wait_clks(BIT / 2);
        rst_n = 1'b0;
        #1;
        check("rstmid_async_count", fifo_count, 0);
        check("rstmid_async_valid", m_valid, 0);
        wait_clks(3);
        rst_n = 1'b1;
        rx_i = 1'b1;
        wait_clks(2 * BIT);
        m_ready = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(BIT);
        check("rstmid_pops", rxq.size(), 1);
        check("rstmid_data", (rxq.size() > 0) ? rxq[0] : 8'hEE, 8'h3C);
        check("rstmid_flags", {frame_err, parity_err, overrun}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
